// File: rtl/fifo_rr_drain.sv
// Round-robin drain of N first-word-fall-through FIFOs onto one registered
// valid/ready stream, popping bursts of up to MAX_BURST words per grant.

module fifo_rr_drain_chk #(
    parameter int N = 4
) (
    input logic         clk,
    input logic         reset,
    input logic [N-1:0] fifo_rd_en,
    input logic [N-1:0] fifo_rd_empty
);

    a_rd_en_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(fifo_rd_en))
        else $stop;

    a_no_empty_pop: assert property (@(posedge clk) disable iff (!reset)
        ((fifo_rd_en & fifo_rd_empty) == {N{1'b0}}))
        else $stop;

endmodule

module fifo_rr_drain #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4,
    parameter int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   ch_enable,
    input  logic [N-1:0]   fifo_rd_empty,
    input  logic [N*W-1:0] fifo_rd_data,
    output logic [N-1:0]   fifo_rd_en,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [IW-1:0]  out_id,
    input  logic           out_ready,
    output logic           busy
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [IW:0] N_W = (IW + 1)'(N);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [IW-1:0]   rr_ptr_r, rr_ptr_s;
    logic [IW-1:0]   grant_r, grant_s, grant_next_s;
    logic [IW-1:0]   pick_s, idx_s;
    logic [IW:0]     sum_s;
    logic [BW-1:0]   burst_cnt_r, burst_cnt_s;
    logic [N-1:0]    eligible_s;
    logic            found_s, pop_s, grant_empty_s, last_s;
    logic [W-1:0]    grant_data_s;

    assign eligible_s    = ch_enable & ~fifo_rd_empty;
    assign grant_empty_s = fifo_rd_empty[grant_r];
    assign grant_data_s  = fifo_rd_data[grant_r*W +: W];
    assign last_s        = (burst_cnt_r == BW'(MAX_BURST - 1));
    assign grant_next_s  = (grant_r == IW'(N - 1)) ? {IW{1'b0}} : grant_r + IW'(1);
    // A pop needs a granted non-empty FIFO and a free (or draining) output slot.
    assign pop_s         = (state_r == ST_BURST) & ~grant_empty_s & (~out_valid | out_ready);
    assign busy          = (state_r == ST_BURST) | out_valid;

    // Round-robin search: first eligible channel at or above rr_ptr, wrapping at N.
    always_comb begin
        found_s = 1'b0;
        pick_s  = {IW{1'b0}};
        sum_s   = {(IW + 1){1'b0}};
        idx_s   = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            sum_s = {1'b0, rr_ptr_r} + (IW + 1)'(k);
            if (sum_s >= N_W) begin
                idx_s = IW'(sum_s - N_W);
            end else begin
                idx_s = IW'(sum_s);
            end
            if (!found_s && eligible_s[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic for the ARB/BURST controller.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        rr_ptr_s    = rr_ptr_r;
        burst_cnt_s = burst_cnt_r;
        case (state_r)
            ST_ARB: begin
                if (found_s) begin
                    state_s     = ST_BURST;
                    grant_s     = pick_s;
                    burst_cnt_s = {BW{1'b0}};
                end else begin
                    state_s = ST_ARB;
                end
            end
            ST_BURST: begin
                if (pop_s) begin
                    burst_cnt_s = burst_cnt_r + BW'(1);
                    if (last_s) begin
                        state_s  = ST_ARB;
                        rr_ptr_s = grant_next_s;
                    end else begin
                        state_s = ST_BURST;
                    end
                end else if (grant_empty_s) begin
                    state_s  = ST_ARB;
                    rr_ptr_s = grant_next_s;
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s = ST_ARB;
            end
        endcase
    end

    // One-hot pop strobe toward the granted FIFO.
    always_comb begin
        fifo_rd_en = {N{1'b0}};
        if (pop_s) begin
            fifo_rd_en[grant_r] = 1'b1;
        end else begin
            fifo_rd_en = {N{1'b0}};
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_ARB;
            rr_ptr_r    <= {IW{1'b0}};
            grant_r     <= {IW{1'b0}};
            burst_cnt_r <= {BW{1'b0}};
        end else begin
            state_r     <= state_s;
            rr_ptr_r    <= rr_ptr_s;
            grant_r     <= grant_s;
            burst_cnt_r <= burst_cnt_s;
        end
    end

    // Output register; a pop in the same cycle as out_ready replaces the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= {W{1'b0}};
            out_id    <= {IW{1'b0}};
        end else if (pop_s) begin
            out_valid <= 1'b1;
            out_data  <= grant_data_s;
            out_id    <= grant_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    fifo_rr_drain_chk #(.N(N)) u_chk (
        .clk           (clk),
        .reset         (reset),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_empty (fifo_rd_empty)
    );

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: queue-backed FIFOs, a word-level round-robin model
// and directed plus randomized scenarios.

module tb_fifo_rr_drain;

    localparam int N         = 4;
    localparam int W         = 8;
    localparam int MAX_BURST = 4;
    localparam int IW        = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   ch_enable;
    logic [N-1:0]   fifo_rd_empty;
    logic [N*W-1:0] fifo_rd_data;
    logic [N-1:0]   fifo_rd_en;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_id;
    logic           out_ready;
    logic           busy;

    always #5 clk = ~clk;

    fifo_rr_drain #(.N(N), .W(W), .MAX_BURST(MAX_BURST)) dut (
        .clk           (clk),
        .reset         (reset),
        .ch_enable     (ch_enable),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_id        (out_id),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    logic [W-1:0]    fq [N][$];
    logic [W-1:0]    mq [N][$];
    logic [IW+W-1:0] exp_q [$];
    int              grant_log [$];
    logic            trace_q [$];
    int              n_checks = 0;
    int              n_pass = 0;
    int              m_ptr = 0;
    int              stall_pops = 0;
    logic            prev_pop = 1'b0;
    logic            hold_prev = 1'b0;
    logic [IW+W-1:0] prev_word = '0;
    logic [13:0]     pat;
    int              exp_g [8];
    int              exp_m [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic drive_ifc();
        for (int i = 0; i < N; i++) begin
            if (fq[i].size() != 0) begin
                fifo_rd_empty[i]        = 1'b0;
                fifo_rd_data[i*W +: W]  = fq[i][0];
            end else begin
                fifo_rd_empty[i]        = 1'b1;
                fifo_rd_data[i*W +: W]  = '0;
            end
        end
    endtask

    task automatic load(input int ch, input int cnt, input int base, input bit rnd);
        for (int j = 0; j < cnt; j++) begin
            fq[ch].push_back(rnd ? W'($urandom) : W'(base + j));
        end
    endtask

    // Word-level model: whole bursts of min(MAX_BURST, remaining) per grant.
    task automatic start_scenario();
        int g;
        int c;
        bit found;
        drive_ifc();
        exp_q.delete();
        grant_log.delete();
        trace_q.delete();
        prev_pop   = 1'b0;
        stall_pops = 0;
        for (int i = 0; i < N; i++) mq[i] = fq[i];
        for (int iter = 0; iter < 512; iter++) begin
            found = 1'b0;
            g = 0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && ch_enable[c] && mq[c].size() != 0) begin
                    found = 1'b1;
                    g = c;
                end
            end
            if (!found) break;
            for (int b = 0; b < MAX_BURST && mq[g].size() != 0; b++) begin
                exp_q.push_back({IW'(g), mq[g].pop_front()});
            end
            m_ptr = (g + 1) % N;
        end
    endtask

    task automatic cycle();
        logic [N-1:0]    rd_en_v;
        logic [IW+W-1:0] w_v;
        int              ch_v;
        @(negedge clk);
        rd_en_v = fifo_rd_en;
        check("rd_en_legal", 32'(((rd_en_v & fifo_rd_empty) == '0) && $onehot0(rd_en_v)), 32'd1);
        if (hold_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_word", 32'({out_id, out_data}), 32'(prev_word));
        end
        if (out_valid && !out_ready && rd_en_v != '0) stall_pops++;
        ch_v = -1;
        for (int i = 0; i < N; i++) if (rd_en_v[i]) ch_v = i;
        if (ch_v >= 0 && !prev_pop) grant_log.push_back(ch_v);
        prev_pop = (ch_v >= 0);
        trace_q.push_back(prev_pop);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 32'(exp_q.size()), 32'd1);
            end else begin
                w_v = exp_q.pop_front();
                check("out_word", 32'({out_id, out_data}), 32'(w_v));
            end
        end
        hold_prev = out_valid && !out_ready;
        prev_word = {out_id, out_data};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (rd_en_v[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        end
        drive_ifc();
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low for cycles 4..8.
    task automatic drain(input int budget, input int mode);
        int cyc;
        cyc = 0;
        do begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(cyc >= 4 && cyc < 9);
            endcase
            cycle();
            cyc++;
        end while (cyc < budget && (exp_q.size() != 0 || busy));
        check("drained", 32'(exp_q.size()), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_m = '{3, 1, 3, 1};
        pat   = 14'b01111011110110;
        reset = 1'b0;
        ch_enable = 4'hF;
        out_ready = 1'b1;
        fifo_rd_data = '0;
        fifo_rd_empty = '1;
        drive_ifc();
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({out_valid, busy, fifo_rd_en}), 32'd0);
        end
        @(posedge clk);
        #1;

        // Round-robin fairness from pointer 0.
        for (int c = 0; c < N; c++) load(c, 8, 0, 1'b1);
        start_scenario();
        drain(300, 0);
        check("fair_bursts", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) check("fair_grant", 32'(grant_log[i]), 32'(exp_g[i]));

        // Single channel, 10 words: bursts 4,4,2 with one bubble each.
        load(2, 10, 32'h20, 1'b0);
        start_scenario();
        drain(300, 0);
        check("single_len", 32'(trace_q.size()), 32'd14);
        for (int i = 0; i < 14 && i < trace_q.size(); i++) check("single_pop", 32'(trace_q[i]), 32'(pat[13-i]));

        // Enable mask 1010 with the pointer left at 3.
        ch_enable = 4'b1010;
        for (int c = 0; c < N; c++) load(c, 8, 0, 1'b1);
        start_scenario();
        drain(300, 0);
        check("mask_bursts", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) check("mask_grant", 32'(grant_log[i]), 32'(exp_m[i]));
        check("mask_ch0_kept", 32'(fq[0].size()), 32'd8);
        check("mask_ch2_kept", 32'(fq[2].size()), 32'd8);

        // Backpressure: five cycles of out_ready low mid-burst.
        ch_enable = 4'hF;
        load(1, 5, 0, 1'b1);
        start_scenario();
        drain(400, 2);
        check("stall_pops_le1", 32'(stall_pops <= 1), 32'd1);

        // Randomized fills, enables and ready.
        for (int it = 0; it < 6; it++) begin
            ch_enable = 4'($urandom_range(1, 15));
            for (int c = 0; c < N; c++) load(c, $urandom_range(0, 6), 0, 1'b1);
            start_scenario();
            drain(1000, 1);
        end

        ch_enable = 4'hF;
        start_scenario();
        drain(1000, 0);

        // Async reset while channel 1 is bursting.
        load(1, 6, 0, 1'b1);
        start_scenario();
        repeat (3) cycle();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        load(0, 2, 0, 1'b1);
        load(3, 3, 0, 1'b1);
        drive_ifc();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_ptr = 0;
        hold_prev = 1'b0;
        start_scenario();
        drain(300, 0);
        check("post_rst_grant", 32'((grant_log.size() != 0) ? grant_log[0] : -1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain.md
Name: fifo_rr_drain

Overview:
- Round-robin scheduler that shares one output stream between N sync_fifo read ports.
- Each FIFO is first-word-fall-through: rd_data is valid whenever rd_empty is 0, and rd_en pops it.
- The block grants one FIFO at a time for bursts of up to MAX_BURST words, pops it, and presents the words on a registered valid/ready output tagged with the source channel.
- It sits between per-requester sync_fifo instances and a single downstream consumer, such as an AXI write-data packer.

Parameters:
- N, 4, number of FIFO channels (≥2).
- W, 8, data width per channel.
- MAX_BURST, 4, maximum words popped per grant (≥1).
- IW, $clog2(N), channel index width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ch_enable  in  N  per-channel arbitration enable; sampled only in ARB.
- fifo_rd_empty  in  N  rd_empty from each FIFO.
- fifo_rd_data  in  N*W  flattened rd_data; channel i occupies bits [i*W +: W].
- fifo_rd_en  out  N  one-hot pop strobe to each FIFO (combinational).
- out_valid  out  1  output word valid.
- out_data  out  W  output word.
- out_id  out  IW  source channel of out_data.
- out_ready  in  1  downstream accept.
- busy  out  1  high while in BURST or while out_valid is high.

Behaviour:
- Reset (async assert, sync deassert):
  - state=ARB, rr_ptr=0, grant=0, burst_cnt=0.
  - out_valid=0, out_data=0, out_id=0.
  - fifo_rd_en=0, busy=0.
- State ARB:
  - Eligible channel: ch_enable[i] & ~fifo_rd_empty[i].
  - Select the first eligible channel searching upward from rr_ptr, with wrap N-1→0.
  - If any channel is eligible: latch it into grant, clear burst_cnt, and go to BURST.
  - Otherwise stay in ARB.
  - No pop occurs in ARB, so each grant costs one bubble cycle.
- Pop condition: pop = (state==BURST) & ~fifo_rd_empty[grant] & (~out_valid | out_ready).
  - fifo_rd_en[grant] = pop; all other bits are 0.
  - fifo_rd_en is never asserted to an empty FIFO.
- Output register:
  - On pop: out_data ← fifo_rd_data[grant], out_id ← grant, out_valid ← 1.
  - Else if out_ready: out_valid ← 0.
  - The output holds stable while out_valid & ~out_ready.
  - Pop-to-out_valid latency is 1 cycle.
  - With out_ready held high, the output sustains 1 word/cycle within a burst.
- State BURST:
  - A pop increments burst_cnt.
  - Leave BURST for ARB when either:
    - pop occurs with burst_cnt == MAX_BURST-1 (burst limit reached), or
    - fifo_rd_empty[grant]==1 in a cycle with no pop (FIFO drained).
  - On leaving BURST: rr_ptr ← (grant+1) mod N.
  - Output backpressure does not end a burst; the block waits in BURST.
- ch_enable changes:
  - Dropping ch_enable[grant] during BURST does not abort the burst; it completes.
  - The change takes effect at the next ARB.
- Simultaneous pop and out_ready in the same cycle: the new word replaces the old one, and out_valid stays 1.
- Width rules:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr wraps modulo N; non-power-of-2 N must wrap correctly, with no out-of-range index.
- busy = (state==BURST) | out_valid.
- Reset mid-burst:
  - All state clears immediately.
  - A word held in the output register is discarded.
  - A FIFO word not yet popped stays in its FIFO.
- Simulation checks (translate_off):
  - $stop if fifo_rd_en is not one-hot-or-zero.
  - $stop if fifo_rd_en[i] is asserted while fifo_rd_empty[i] is high.

Test Plan:
- Reset then idle:
  - Stimulus: reset=0 for 3 cycles, then reset=1, with all FIFOs empty.
  - Required: out_valid=0, fifo_rd_en=0, busy=0 for 20 cycles.
- Single channel, long run:
  - Stimulus: N=4, MAX_BURST=4, ch2 holds 10 words (0x20..0x29), out_ready=1.
  - Required: bursts of 4, 4 and 2 words, each burst preceded by 1 ARB bubble; output in order with out_id=2.
- Round-robin fairness:
  - Stimulus: all 4 channels hold 8 words each, out_ready=1.
  - Required grant order 0,1,2,3,0,1,2,3; each burst is 4 words; 32 words total, with no loss or reorder within a channel.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles mid-burst.
  - Required: out_data and out_id are stable, at most 1 pop occurs while out_valid=1 & ~out_ready, and the sequence resumes without loss.
- Enable mask and wrap:
  - Stimulus: ch_enable=4'b1010, all FIFOs non-empty, rr_ptr=3.
  - Required: grants alternate 3,1,3,1; channels 0 and 2 are never popped.
- Async reset mid-burst:
  - Stimulus: assert reset off-edge while ch1 is bursting.
  - Required: out_valid and fifo_rd_en drop to 0 immediately; after release the next grant comes from a search starting at channel 0.
